// File: rtl/cu_mc_if.sv
// ID-stage <-> control-unit bundle: raw instruction fields in, decoded controls and
// multi-cycle MDU sequencing status out.
interface cu_mc_if #(
  parameter int ALUCTRL_W = 5
);
  logic                 id_valid_i;
  logic [6:0]           id_opcode_i;
  logic [2:0]           id_func3_i;
  logic [6:0]           id_func7_i;
  logic                 flush_i;
  logic [ALUCTRL_W-1:0] cu_ALUctrl_o;
  logic                 cu_reg_we_o;
  logic                 cu_op_b_sel_o;
  logic                 cu_reg1_RE_o;
  logic                 cu_reg2_RE_o;
  logic                 cu_mdu_start_o;
  logic [2:0]           cu_mdu_op_o;
  logic                 cu_stall_o;
  logic                 cu_busy_o;
  logic                 cu_illegal_o;

  modport master (
    output id_valid_i, id_opcode_i, id_func3_i, id_func7_i, flush_i,
    input  cu_ALUctrl_o, cu_reg_we_o, cu_op_b_sel_o, cu_reg1_RE_o, cu_reg2_RE_o,
           cu_mdu_start_o, cu_mdu_op_o, cu_stall_o, cu_busy_o, cu_illegal_o
  );

  modport slave (
    input  id_valid_i, id_opcode_i, id_func3_i, id_func7_i, flush_i,
    output cu_ALUctrl_o, cu_reg_we_o, cu_op_b_sel_o, cu_reg1_RE_o, cu_reg2_RE_o,
           cu_mdu_start_o, cu_mdu_op_o, cu_stall_o, cu_busy_o, cu_illegal_o
  );
endinterface

// File: rtl/cu_mc.sv
// RV32I(M) control unit: same-cycle decode plus an IDLE/BUSY/DONE sequencer that
// stalls IF/ID while a multi-cycle multiply/divide is in flight.
module cu_mc #(
  parameter bit M_EXT     = 1'b1,
  parameter int MUL_LAT   = 2,
  parameter int DIV_LAT   = 33,
  parameter int ALUCTRL_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  cu_mc_if.slave bus
);
  localparam logic [ALUCTRL_W-1:0] ALU_NO_OP = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_ADD   = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB   = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL   = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT   = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR   = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL   = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA   = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_OR    = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_AND   = ALUCTRL_W'(10);
  localparam logic [ALUCTRL_W-1:0] ALU_EQU   = ALUCTRL_W'(11);
  localparam logic [ALUCTRL_W-1:0] ALU_NEQ   = ALUCTRL_W'(12);
  localparam logic [ALUCTRL_W-1:0] ALU_SGE   = ALUCTRL_W'(13);
  localparam logic [ALUCTRL_W-1:0] ALU_SGEU  = ALUCTRL_W'(14);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           mdu_op_q;

  logic [ALUCTRL_W-1:0] dec_alu;
  logic                 dec_we, dec_opb, dec_r1, dec_r2, dec_ill, dec_m;
  logic                 legal, start;

  function automatic logic [ALUCTRL_W-1:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_alu = ALU_NO_OP;
    dec_we  = 1'b0;
    dec_opb = 1'b0;
    dec_r1  = 1'b0;
    dec_r2  = 1'b0;
    dec_ill = 1'b0;
    dec_m   = 1'b0;
    case (bus.id_opcode_i)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        dec_alu = ALU_ADD; dec_we = 1'b1; dec_opb = 1'b1;
      end
      OP_JALR, OP_LOAD: begin
        dec_alu = ALU_ADD; dec_we = 1'b1; dec_opb = 1'b1; dec_r1 = 1'b1;
      end
      OP_STORE: begin
        dec_alu = ALU_ADD; dec_opb = 1'b1; dec_r1 = 1'b1; dec_r2 = 1'b1;
      end
      OP_IMM: begin
        dec_alu = f3_alu(bus.id_func3_i);
        dec_we  = 1'b1; dec_opb = 1'b1; dec_r1 = 1'b1;
        if (bus.id_func3_i == 3'b001 && bus.id_func7_i != F7_BASE) dec_ill = 1'b1;
        if (bus.id_func3_i == 3'b101) begin
          if (bus.id_func7_i == F7_ALT)        dec_alu = ALU_SRA;
          else if (bus.id_func7_i != F7_BASE)  dec_ill = 1'b1;
        end
      end
      OP_BRANCH: begin
        dec_r1 = 1'b1; dec_r2 = 1'b1;
        case (bus.id_func3_i)
          3'b000:  dec_alu = ALU_EQU;
          3'b001:  dec_alu = ALU_NEQ;
          3'b100:  dec_alu = ALU_SLT;
          3'b101:  dec_alu = ALU_SGE;
          3'b110:  dec_alu = ALU_SLTU;
          3'b111:  dec_alu = ALU_SGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      OP_REG: begin
        dec_r1 = 1'b1; dec_r2 = 1'b1;
        if (bus.id_func7_i == F7_BASE) begin
          dec_we = 1'b1; dec_alu = f3_alu(bus.id_func3_i);
        end else if (bus.id_func7_i == F7_ALT &&
                     (bus.id_func3_i == 3'b000 || bus.id_func3_i == 3'b101)) begin
          dec_we = 1'b1; dec_alu = bus.id_func3_i[2] ? ALU_SRA : ALU_SUB;
        end else if (M_EXT && bus.id_func7_i == F7_MUL) begin
          dec_m = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_FENCE, OP_SYSTEM: ;
      default: dec_ill = 1'b1;
    endcase
  end

  assign legal = bus.id_valid_i & ~dec_ill;
  // Reset gates start directly so a held M op cannot fire while rst_n is low.
  assign start = rst_n & (state_q == IDLE) & legal & dec_m & ~bus.flush_i;

  always_comb begin
    bus.cu_ALUctrl_o   = legal ? dec_alu : ALU_NO_OP;
    bus.cu_reg_we_o    = (legal & dec_we) | ((state_q == DONE) & ~bus.flush_i);
    bus.cu_op_b_sel_o  = legal & dec_opb;
    bus.cu_reg1_RE_o   = legal & dec_r1;
    bus.cu_reg2_RE_o   = legal & dec_r2;
    bus.cu_illegal_o   = bus.id_valid_i & dec_ill;
    bus.cu_mdu_start_o = start;
    bus.cu_stall_o     = start | ((state_q == BUSY) & ~bus.flush_i);
    bus.cu_busy_o      = (state_q != IDLE);
    bus.cu_mdu_op_o    = mdu_op_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = BUSY;
          cnt_d   = bus.id_func3_i[2] ? DIV_CNT : MUL_CNT;
        end
        BUSY: if (cnt_q == '0) state_d = DONE;
              else             cnt_d   = cnt_q - 1'b1;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mdu_op_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) mdu_op_q <= bus.id_func3_i;
    end
  end
endmodule

// File: doc/cu_mc.md
CU_MC -- requirements
Module: cu_mc

Interface
REQ-001 SHALL have parameter M_EXT, default 1, enabling RV32M decode; 0 treats func7=0000001 R-type as illegal.
REQ-002 SHALL have parameter MUL_LAT, default 2, giving the MUL/MULH/MULHSU/MULHU busy cycles; legal range is 1 or more.
REQ-003 SHALL have parameter DIV_LAT, default 33, giving the DIV/DIVU/REM/REMU busy cycles; legal range is 1 or more.
REQ-004 SHALL have parameter ALUCTRL_W, default 5, setting the ALU control width; codes are the define.v macros.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- id_valid_i, in, 1, ID holds a valid instruction.
- id_opcode_i, in, 7, opcode.
- id_func3_i, in, 3, func3.
- id_func7_i, in, 7, func7.
- flush_i, in, 1, kill the instruction in ID or in flight.
- cu_ALUctrl_o, out, ALUCTRL_W, ALU operation.
- cu_reg_we_o, out, 1, register-file write enable.
- cu_op_b_sel_o, out, 1, operand B select: 0 = reg, 1 = imm.
- cu_reg1_RE_o, out, 1, rs1 read enable (to dhnf).
- cu_reg2_RE_o, out, 1, rs2 read enable (to dhnf).
- cu_mdu_start_o, out, 1, one-cycle MDU start pulse.
- cu_mdu_op_o, out, 3, latched func3 of the in-flight M op.
- cu_stall_o, out, 1, hold IF/ID.
- cu_busy_o, out, 1, FSM not IDLE.
- cu_illegal_o, out, 1, illegal encoding in ID.

Function
REQ-006 SHALL decode base RV32I combinationally, same cycle, into ALUctrl/reg_we/op_b_sel/reg1_RE/reg2_RE:
- I-ALU: func3 selects ADD/SLT/SLTU/XOR/OR/AND/SLL; SRLI/SRAI by func7.
- Loads, JALR, LUI, AUIPC, JAL: ADD.
- Stores: ADD, we=0.
- Branches: EQU/NEQ/SLT/SGE/SLTU/SGEU, we=0.
- R-type: ADD/SUB, SRL/SRA by func7.
- FENCE, SYSTEM: NO_OP, we=0.
REQ-007 op_b_sel SHALL be 1 for JALR, loads, I-ALU, LUI, AUIPC, JAL and stores; else 0.
REQ-008 reg1_RE SHALL be 1 for JALR, loads, I-ALU, branches, stores and R-type (incl. M); reg2_RE SHALL be 1 for branches, stores and R-type (incl. M).
REQ-009 cu_illegal_o SHALL be 1 for any of:
- unknown opcode;
- undefined func3 for branch;
- R-type func7 not 0000000/0100000 (0100000 valid only for func3 000/101), unless M_EXT=1 and func7=0000001;
- SRLI/SRAI or SLLI with bad func7.
Illegal decode SHALL force ALUctrl=NO_OP, we=0, both RE=0, start=0.
REQ-010 id_valid_i=0 SHALL force ALUctrl=NO_OP and we, RE, start, illegal all 0; the FSM is unaffected.
REQ-011 FSM states SHALL be IDLE, BUSY, DONE. Down-counter width SHALL be clog2(max(MUL_LAT,DIV_LAT)+1).
REQ-012 IDLE with valid M op and flush_i=0 (cycle T):
- start=1 and stall=1 combinationally;
- cu_mdu_op_o <= func3;
- cnt <= (func3[2] ? DIV_LAT : MUL_LAT) - 1;
- state <= BUSY.
REQ-013 BUSY SHALL hold stall=1 and decrement cnt each cycle; at cnt==0 it SHALL move to DONE.
- Stall is high for exactly LAT+1 cycles (T..T+LAT).
- DONE occurs at T+LAT+1.
REQ-014 DONE SHALL drive stall=0, reg_we=1 and start=0, then go unconditionally to IDLE; an M op is never restarted from DONE.
REQ-015 For M ops, ALUctrl SHALL be NO_OP, and reg_we SHALL be 0 in every cycle except DONE.
REQ-016 flush_i SHALL win over start and over DONE.
- Any state: next state IDLE, cnt 0, no reg_we pulse, stall=0 that cycle.
- IDLE with M op and flush_i=1: no start.
REQ-017 Back-to-back M ops SHALL restart from IDLE the cycle after DONE, with no lost or duplicated start.
REQ-018 cu_busy_o SHALL be registered state != IDLE.

Reset
REQ-019 rst_n=0 SHALL immediately, regardless of clk:
- set state IDLE, cnt 0, cu_mdu_op_o 0;
- drive busy, stall and start to 0;
- discard any in-flight op, with no write-back after release.
REQ-020 Combinational decode outputs SHALL follow inputs during reset, except start=0 and stall=0.

Verification
REQ-021 ADDI (0010011, f3 000), valid=1 -> same cycle: ALUctrl=`ADD, we=1, op_b_sel=1, reg1_RE=1, reg2_RE=0, stall=0, illegal=0.
REQ-022 MUL (0110011, f3 000, f7 0000001), MUL_LAT=2, at T:
- start=1 at T only;
- stall=1 over T..T+2;
- T+3: stall=0, reg_we=1, mdu_op=000;
- T+4: busy=0.
REQ-023 DIVU (f3 101), DIV_LAT=33, at T -> stall=1 over T..T+33; reg_we=1 at T+34; mdu_op=101.
REQ-024 DIV started at T, flush_i=1 at T+10 -> busy=0 at T+11; no reg_we pulse; next M op starts normally.
REQ-025 M_EXT=0, MUL encoding -> illegal=1, start=0, stall=0, we=0, ALUctrl=`NO_OP.
REQ-026 rst_n low at T+5 of a DIV -> busy, stall and start 0 asynchronously; no reg_we after release.
